// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, issue-mark and hazard-query signals for regfile_wb_arbiter.
// master = requesters/issue stage, slave = arbiter.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;

    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        busy_a;
    logic        busy_b;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               iss_valid, iss_rd, ra_addr, rb_addr,
        input  alu_ready, lsu_ready, w_en, w_addr, w_data, busy_a, busy_b
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               iss_valid, iss_rd, ra_addr, rb_addr,
        output alu_ready, lsu_ready, w_en, w_addr, w_data, busy_a, busy_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ALU/LSU writeback arbiter with pending-register scoreboard; write port registered, 1-cycle latency.
// Ready is granted to one valid channel per cycle; REGFILE_WB_ARB_ROUND_ROBIN_EN selects round-robin, else LSU-first.
module regfile_wb_arbiter (
    input  logic                       clk,
    input  logic                       reset,
    regfile_wb_arbiter_if.slave        bus
);
    logic        grant_lsu;
    logic        alu_ready;
    logic        lsu_ready;
    logic        hs;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    logic        w_en_q;
    logic [4:0]  w_addr_q;
    logic [31:0] w_data_q;
    logic [31:0] pending;
    logic [31:0] pending_next;

`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
    // last_lsu=1 means LSU won the previous handshake, so ALU wins the next conflict.
    logic last_lsu;

    always_comb begin
        grant_lsu = bus.lsu_valid && (!bus.alu_valid || !last_lsu);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_lsu <= 1'b1;
        end else if (hs) begin
            last_lsu <= grant_lsu;
        end
    end
`else
    always_comb begin
        grant_lsu = bus.lsu_valid;
    end
`endif

    always_comb begin
        alu_ready = reset && bus.alu_valid && !grant_lsu;
        lsu_ready = reset && grant_lsu;
        hs        = alu_ready || lsu_ready;
        win_rd    = grant_lsu ? bus.lsu_rd   : bus.alu_rd;
        win_data  = grant_lsu ? bus.lsu_data : bus.alu_data;
    end

    // Clear before set so a same-edge re-issue keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (w_en_q) begin
            pending_next[w_addr_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            pending_next[bus.iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_en_q   <= 1'b0;
            w_addr_q <= 5'd0;
            w_data_q <= 32'd0;
            pending  <= 32'd0;
        end else begin
            w_en_q  <= hs && (win_rd != 5'd0);
            pending <= pending_next;
            if (hs) begin
                w_addr_q <= win_rd;
                w_data_q <= win_data;
            end
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.lsu_ready = lsu_ready;
    assign bus.w_en      = w_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.busy_a    = (bus.ra_addr != 5'd0) && pending[bus.ra_addr];
    assign bus.busy_b    = (bus.rb_addr != 5'd0) && pending[bus.rb_addr];
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input 32, alu_ready output 1: ALU writeback request channel.
REQ-004 SHALL have ports lsu_valid input 1, lsu_rd input 5, lsu_data input 32, lsu_ready output 1: load-unit writeback request channel.
REQ-005 SHALL have ports w_en output 1, w_addr output 5, w_data output 32: registered drive of the register-file write port.
REQ-006 SHALL have ports iss_valid input 1, iss_rd input 5: issue stage marks destination register as pending.
REQ-007 SHALL have ports ra_addr input 5, rb_addr input 5, busy_a output 1, busy_b output 1: hazard query for the two read ports.

Function
REQ-008 SHALL complete a handshake on a channel when its valid and ready are both 1 at a rising edge; at most one handshake per cycle.
REQ-009 SHALL assert a ready combinationally only for the single granted channel, and only when that channel's valid is 1.
REQ-010 SHALL grant the only requesting channel when exactly one valid is 1, irrespective of arbitration mode.
REQ-011 SHALL, on the edge completing a handshake, register w_addr/w_data from the winner; w_en SHALL be 1 in the following cycle only (1-cycle latency), else 0.
REQ-012 SHALL treat rd = 0 as accepted-but-dropped: handshake completes, w_en stays 0, w_addr/w_data still update.
REQ-013 SHALL hold a 32-bit pending mask; iss_valid=1 with iss_rd!=0 sets pending[iss_rd] at the edge.
REQ-014 SHALL clear pending[w_addr] at the rising edge where w_en=1.
REQ-015 SHALL give set priority when set and clear target the same register on the same edge (bit stays 1).
REQ-016 SHALL drive busy_a = pending[ra_addr], busy_b = pending[rb_addr] combinationally; address 0 always yields 0.
REQ-017 SHALL never set or clear pending[0]; it reads 0 at all times.
REQ-018 SHALL not require requesters to drop valid after a grant; back-to-back handshakes from one channel on consecutive cycles are legal.
REQ-019 SHALL allow a requester to hold valid with stable rd/data while not granted; payload changes while waiting are undefined.

Reset
REQ-020 SHALL, while reset=0 at a rising edge, clear pending mask, w_en, w_addr, w_data to 0 and set arbitration state to "ALU next".
REQ-021 SHALL discard any handshake coinciding with reset=0 (no w_en pulse follows); ready outputs are 0 while reset=0.
REQ-022 SHALL drive busy_a/busy_b as 0 from the first cycle after reset until a new set occurs.

Configuration
REQ-023 SHALL use macro REGFILE_WB_ARB_ROUND_ROBIN_EN to select conflict resolution.
REQ-024 SHALL, with REGFILE_WB_ARB_ROUND_ROBIN_EN defined, grant the channel not granted at the previous conflict-free or conflicting handshake (1-bit last-grant flop, updated on every handshake; after reset ALU wins first conflict).
REQ-025 SHALL, without REGFILE_WB_ARB_ROUND_ROBIN_EN, use fixed priority LSU over ALU; last-grant flop absent.

Verification
REQ-026 SHALL cover: alu_valid=1 rd=5 data=0xDEADBEEF, lsu idle -> alu_ready=1 same cycle; next cycle w_en=1 w_addr=5 w_data=0xDEADBEEF; cycle after w_en=0.
REQ-027 SHALL cover: both valid for 4 cycles (alu rd=1, lsu rd=2) -> round-robin: writes to 1,2,1,2; fixed: 2,2,2,2 with alu_ready=0 throughout.
REQ-028 SHALL cover: iss_valid rd=7, then ra_addr=7 -> busy_a=1; alu write rd=7 -> busy_a=1 through w_en cycle, 0 the cycle after.
REQ-029 SHALL cover: w_en=1 w_addr=9 on same edge as iss_valid rd=9 -> pending[9] remains 1, busy stays 1.
REQ-030 SHALL cover: lsu write rd=0 data=0x1234 -> lsu_ready=1, w_en stays 0; iss_rd=0 -> busy for address 0 stays 0.
REQ-031 SHALL cover: reset=0 asserted in handshake cycle of alu rd=3 with pending[3]=1 -> no w_en next cycle, busy for 3 reads 0, first later conflict granted to ALU (round-robin build).
